// File: rtl/model_stream_adapter.sv
// Stream front/back end for the model core: collects XD input words onto model_x,
// pulses model_en, captures model_y after LAT cycles and streams YD result words out.
module model_stream_adapter #(
  parameter int unsigned XD  = 64,
  parameter int unsigned XB  = 11,
  parameter int unsigned YD  = 16,
  parameter int unsigned YB  = 10,
  parameter int unsigned LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [XB-1:0]    s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [YB-1:0]    m_data,
  output logic             m_last,
  output logic [XD*XB-1:0] model_x,
  output logic             model_en,
  input  logic [YD*YB-1:0] model_y,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned IW = (XD > 1) ? $clog2(XD) : 1;
  localparam int unsigned OW = (YD > 1) ? $clog2(YD) : 1;
  localparam int unsigned WW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [IW-1:0] ILAST = IW'(XD - 1);
  localparam logic [OW-1:0] OLAST = OW'(YD - 1);
  localparam logic [WW-1:0] WINIT = WW'(LAT - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_FIRE, ST_WAIT, ST_DRAIN} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_icnt;
  logic [OW-1:0]    r_ocnt;
  logic [WW-1:0]    r_wcnt;
  logic [YD*YB-1:0] r_yreg;

  logic             w_in_hs;
  logic             w_out_hs;
  logic [OW-1:0]    w_onext;

  assign w_in_hs  = s_valid & s_ready;
  assign w_out_hs = m_valid & m_ready;
  assign w_onext  = r_ocnt + OW'(1);

  // Frame sequencer; every output is a register so m_data never depends on m_ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_LOAD;
      r_icnt    <= '0;
      r_ocnt    <= '0;
      r_wcnt    <= '0;
      r_yreg    <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      model_x   <= '0;
      model_en  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      model_en  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          if (w_in_hs) begin
            model_x[r_icnt*XB +: XB] <= s_data;
            if (r_icnt == ILAST) begin
              // A missing s_last on the final word is flagged but the frame still runs.
              r_icnt    <= '0;
              r_state   <= ST_FIRE;
              s_ready   <= 1'b0;
              busy      <= 1'b1;
              model_en  <= 1'b1;
              frame_err <= ~s_last;
            end else if (s_last) begin
              r_icnt    <= '0;
              frame_err <= 1'b1;
            end else begin
              r_icnt <= r_icnt + IW'(1);
            end
          end
        end
        ST_FIRE: begin
          r_wcnt  <= WINIT;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wcnt == '0) begin
            r_yreg  <= model_y;
            r_ocnt  <= '0;
            m_valid <= 1'b1;
            m_data  <= model_y[YB-1:0];
            m_last  <= (YD == 1);
            r_state <= ST_DRAIN;
          end else begin
            r_wcnt <= r_wcnt - WW'(1);
          end
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            if (r_ocnt == OLAST) begin
              r_ocnt  <= '0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              s_ready <= 1'b1;
              r_state <= ST_LOAD;
            end else begin
              r_ocnt <= w_onext;
              m_data <= r_yreg[w_onext*YB +: YB];
              m_last <= (w_onext == OLAST);
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_model_stream_adapter.sv
// Randomised self-checking bench: two adapters (LAT=1 and LAT=3) with noisy model stubs,
// checked every cycle against a frame-level reference model.
module tb_model_stream_adapter;

  localparam int unsigned XD = 64;
  localparam int unsigned XB = 11;
  localparam int unsigned YD = 16;
  localparam int unsigned YB = 10;

  logic clk;
  logic rstn;

  logic             s_valid   [2];
  logic             s_ready   [2];
  logic [XB-1:0]    s_data    [2];
  logic             s_last    [2];
  logic             m_valid   [2];
  logic             m_ready   [2];
  logic [YB-1:0]    m_data    [2];
  logic             m_last    [2];
  logic [XD*XB-1:0] model_x   [2];
  logic             model_en  [2];
  logic             frame_err [2];
  logic             busy      [2];

  int checks;
  int failures;

  // Reference model state, one slot per adapter
  logic [XB-1:0] xw   [2][XD];
  logic [YB-1:0] expw [2][YD];
  int  icnt [2];
  int  wait_n [2];
  int  opos [2];
  int  en_cnt [2];
  int  err_cnt [2];
  bit  pend_en [2];
  bit  pend_err [2];
  bit  mbusy [2];
  bit  startup [2];
  bit  draining [2];

  logic [XB-1:0] fw [XD];
  logic [YB-1:0] logd [YD];
  bit            logl [YD];
  int            nx;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model stub: y = x+1 per word, but only the value launched LAT edges after en is sane.
  for (genvar g = 0; g < 2; g++) begin : gu
    localparam int unsigned L = (g == 0) ? 1 : 3;
    logic [YD*YB-1:0] y;
    int kc;

    always @(posedge clk) begin
      int kk;
      kk = model_en[g] ? 1 : ((kc != 0 && kc < 8) ? kc + 1 : 0);
      kc <= kk;
      for (int k = 0; k < YD; k++)
        y[k*YB +: YB] <= (kk == int'(L)) ? YB'(model_x[g][k*XB +: XB] + 1) : YB'($urandom);
    end

    model_stream_adapter #(.XD(XD), .XB(XB), .YD(YD), .YB(YB), .LAT(L)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .s_valid   (s_valid[g]),
      .s_ready   (s_ready[g]),
      .s_data    (s_data[g]),
      .s_last    (s_last[g]),
      .m_valid   (m_valid[g]),
      .m_ready   (m_ready[g]),
      .m_data    (m_data[g]),
      .m_last    (m_last[g]),
      .model_x   (model_x[g]),
      .model_en  (model_en[g]),
      .model_y   (y),
      .frame_err (frame_err[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[u%0d] t=%0t got=%0h expected=%0h", nm, u, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both adapters against the frame-level model
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (!rstn) begin
          chk("rst_m_valid", u, 32'(m_valid[u]), 32'(0));
          for (int k = 0; k < XD; k++) xw[u][k] = '0;
          icnt[u] = 0; wait_n[u] = 0; opos[u] = 0;
          pend_en[u] = 0; pend_err[u] = 0; mbusy[u] = 0; draining[u] = 0; startup[u] = 1;
        end else begin
          if (wait_n[u] > 0) begin
            wait_n[u]--;
            if (wait_n[u] == 0) draining[u] = 1;
          end
          chk("s_ready", u, 32'(s_ready[u]), 32'(!mbusy[u] && !startup[u]));
          chk("busy", u, 32'(busy[u]), 32'(mbusy[u]));
          chk("frame_err", u, 32'(frame_err[u]), 32'(pend_err[u]));
          chk("model_en", u, 32'(model_en[u]), 32'(pend_en[u]));
          if (model_en[u]) en_cnt[u]++;
          if (frame_err[u]) err_cnt[u]++;
          if (pend_en[u])
            for (int k = 0; k < XD; k++)
              chk("model_x", u, 32'(model_x[u][k*XB +: XB]), 32'(xw[u][k]));
          chk("m_valid", u, 32'(m_valid[u]), 32'(draining[u]));
          if (draining[u] && m_valid[u]) begin
            chk("m_data", u, 32'(m_data[u]), 32'(expw[u][opos[u]]));
            chk("m_last", u, 32'(m_last[u]), 32'(opos[u] == YD - 1));
            if (m_ready[u]) begin
              opos[u]++;
              if (opos[u] == YD) begin
                opos[u] = 0; draining[u] = 0; mbusy[u] = 0;
              end
            end
          end
          startup[u] = 0; pend_en[u] = 0; pend_err[u] = 0;
          if (s_valid[u] && s_ready[u]) begin
            xw[u][icnt[u]] = s_data[u];
            if (icnt[u] == XD - 1) begin
              icnt[u] = 0; pend_en[u] = 1; pend_err[u] = !s_last[u];
              mbusy[u] = 1; wait_n[u] = lat_of(u) + 2;
              for (int k = 0; k < YD; k++) expw[u][k] = YB'(xw[u][k] + 1);
            end else if (s_last[u]) begin
              icnt[u] = 0; pend_err[u] = 1;
            end else begin
              icnt[u]++;
            end
          end
        end
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < XD; i++) fw[i] = XB'($urandom);
  endtask

  // gap: 0 back-to-back, 1 idle cycle after every word, 2 random idles
  task automatic send_frame(input int u, input int nw, input int last_idx, input int gap);
    bit acc;
    int g;
    for (int i = 0; i < nw; i++) begin
      s_valid[u] = 1'b1;
      s_data[u]  = fw[i];
      s_last[u]  = (i == last_idx);
      g = 0;
      do begin
        @(negedge clk);
        acc = s_ready[u];
        @(posedge clk); #1;
        g++;
      end while (!acc && g < 500);
      if (!acc) chk("send_timeout", u, 32'(0), 32'(1));
      s_valid[u] = 1'b0;
      s_last[u]  = 1'b0;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // mode: 0 always ready, 1 three-cycle stall on word 7, 2 random m_ready
  task automatic drain(input int u, input int mode);
    int g;
    int sd;
    g = 0; sd = 0; nx = 0;
    while (busy[u] && g < 2000) begin
      @(negedge clk);
      if (m_valid[u] && m_ready[u] && nx < YD) begin
        logd[nx] = m_data[u];
        logl[nx] = m_last[u];
        nx++;
      end
      @(posedge clk); #1;
      g++;
      if (mode == 1 && nx == 7 && sd < 3) begin
        m_ready[u] = 1'b0;
        sd++;
      end else if (mode == 2) begin
        m_ready[u] = 1'($urandom_range(0, 1));
      end else begin
        m_ready[u] = 1'b1;
      end
    end
    m_ready[u] = 1'b1;
    chk("drain_timeout", u, 32'(busy[u]), 32'(0));
    chk("xfer_count", u, 32'(nx), 32'(YD));
  endtask

  initial begin
    int en0;
    int er0;
    int g;
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    for (int u = 0; u < 2; u++) begin
      s_valid[u] = 1'b0; s_data[u] = '0; s_last[u] = 1'b0; m_ready[u] = 1'b1;
      en_cnt[u] = 0; err_cnt[u] = 0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_s_ready", u, 32'(s_ready[u]), 32'(0));
      chk("rst_m_last", u, 32'(m_last[u]), 32'(0));
      chk("rst_m_data", u, 32'(m_data[u]), 32'(0));
      chk("rst_model_en", u, 32'(model_en[u]), 32'(0));
      chk("rst_frame_err", u, 32'(frame_err[u]), 32'(0));
      chk("rst_busy", u, 32'(busy[u]), 32'(0));
      chk("rst_model_x", u, 32'(|model_x[u]), 32'(0));
    end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Counting frame, y[k] = k+1
    for (int i = 0; i < XD; i++) fw[i] = XB'(i);
    en0 = en_cnt[0]; er0 = err_cnt[0];
    send_frame(0, XD, XD - 1, 0);
    drain(0, 0);
    chk("x_word5", 0, 32'(model_x[0][5*XB +: XB]), 32'(5));
    chk("first_word", 0, 32'(logd[0]), 32'(1));
    chk("last_word", 0, 32'(logd[15]), 32'(16));
    chk("last_flag15", 0, 32'(logl[15]), 32'(1));
    chk("last_flag14", 0, 32'(logl[14]), 32'(0));
    chk("en_pulses_a", 0, 32'(en_cnt[0] - en0), 32'(1));
    chk("err_pulses_a", 0, 32'(err_cnt[0] - er0), 32'(0));

    // Same frame with throttled input and a stall on word 7
    send_frame(0, XD, XD - 1, 1);
    drain(0, 1);
    chk("stall_word7", 0, 32'(logd[7]), 32'(8));
    chk("stall_word8", 0, 32'(logd[8]), 32'(9));
    chk("stall_last", 0, 32'(logd[15]), 32'(16));

    // Early s_last on word 10, then a normal frame
    fill_random();
    en0 = en_cnt[0]; er0 = err_cnt[0];
    send_frame(0, 11, 10, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("early_err", 0, 32'(err_cnt[0] - er0), 32'(1));
    chk("early_no_en", 0, 32'(en_cnt[0] - en0), 32'(0));
    fill_random();
    send_frame(0, XD, XD - 1, 2);
    drain(0, 0);
    chk("after_early_en", 0, 32'(en_cnt[0] - en0), 32'(1));
    chk("after_early_word0", 0, 32'(logd[0]), 32'(YB'(fw[0] + 1)));

    // Full frame without s_last
    fill_random();
    en0 = en_cnt[0]; er0 = err_cnt[0];
    send_frame(0, XD, -1, 0);
    drain(0, 2);
    chk("nolast_err", 0, 32'(err_cnt[0] - er0), 32'(1));
    chk("nolast_en", 0, 32'(en_cnt[0] - en0), 32'(1));

    // Random traffic on both latencies
    for (int r = 0; r < 3; r++) begin
      fill_random();
      send_frame(0, XD, XD - 1, 2);
      drain(0, 2);
      fill_random();
      send_frame(1, XD, XD - 1, 2);
      drain(1, 2);
      chk("lat3_word0", 1, 32'(logd[0]), 32'(YB'(fw[0] + 1)));
    end

    // Asynchronous reset while word 8 is being presented
    fill_random();
    send_frame(0, XD, XD - 1, 0);
    nx = 0; g = 0;
    while (nx < 8 && g < 2000) begin
      @(negedge clk);
      if (m_valid[0] && m_ready[0]) nx++;
      @(posedge clk); #1;
      g++;
    end
    chk("pre_reset_xfers", 0, 32'(nx), 32'(8));
    #1 rstn = 1'b0;
    #1;
    chk("async_m_valid", 0, 32'(m_valid[0]), 32'(0));
    chk("async_busy", 0, 32'(busy[0]), 32'(0));
    chk("async_model_x", 0, 32'(|model_x[0]), 32'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 0, 32'(s_ready[0]), 32'(1));
    fill_random();
    send_frame(0, XD, XD - 1, 0);
    drain(0, 0);
    chk("post_reset_word0", 0, 32'(logd[0]), 32'(YB'(fw[0] + 1)));
    chk("post_reset_last", 0, 32'(logd[15]), 32'(YB'(fw[15] + 1)));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/model_stream_adapter.md
Name: model_stream_adapter

Overview:
- Streaming front/back end for the `model` inference core, which takes a parallel input vector `x`, a one-cycle `en` pulse, and returns a parallel result `y`.
- Input side: deserialises a valid/ready word stream of XD input words into the parallel `x` bus, then fires `en`.
- Output side: waits the model latency, captures `y`, and serialises YD result words back out on a valid/ready stream with `last`.
- Replaces the file-driven stimulus/readback path so the core can be driven from a DMA or host link.

Parameters:
- XD, 64, number of input words per frame.
- XB, 11, bits per input word.
- YD, 16, number of output words per frame.
- YB, 10, bits per output word.
- LAT, 1, cycles from the en-high clock edge to the edge at which model y is valid (LAT >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  adapter accepts an input word.
- s_data  in  XB  input word; word 0 first.
- s_last  in  1  marks the final input word of a frame.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts an output word.
- m_data  out  YB  output word; y[0] first.
- m_last  out  1  high with output word YD-1.
- model_x  out  XD*XB  to model x; word n at bits [n*XB +: XB].
- model_en  out  1  to model en; one-cycle pulse.
- model_y  in  YD*YB  from model y; word n at bits [n*YB +: YB].
- frame_err  out  1  one-cycle pulse on an input framing error.
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (asynchronous, rstn low):
  - All outputs 0; model_x 0; y capture register 0.
  - Input and output counters 0; state LOAD.
  - s_ready rises in the first cycle after rstn deasserts.
  - Reset mid-frame discards all partial input and output; the frame is not resumed.
- States: LOAD, FIRE, WAIT, DRAIN.
- LOAD:
  - s_ready=1, busy=0.
  - On a clock edge where s_valid&&s_ready: write s_data into model_x word[icnt], then icnt++.
  - s_last with icnt<XD-1 (early last):
    - Frame dropped and icnt returns to 0.
    - frame_err pulses next cycle; stay in LOAD.
    - model_x words already written are not cleared.
  - Word XD-1 accepted:
    - icnt returns to 0 and the next state is FIRE.
    - If s_last=0 on that word, frame_err pulses but the frame proceeds.
    - Any following words belong to the next frame.
- FIRE:
  - Exactly one cycle: model_en=1, s_ready=0; then go to WAIT with wcnt=LAT-1.
- WAIT:
  - model_en=0; model_x held stable.
  - wcnt counts down; when wcnt==0, the y register captures model_y on that edge and the next state is DRAIN.
  - Net effect: capture occurs LAT edges after the edge that registered model_en high.
- DRAIN:
  - m_valid=1 and m_data=yreg word[ocnt] (registered, no combinational path from m_ready).
  - m_last=(ocnt==YD-1).
  - On m_valid&&m_ready: ocnt++.
  - When the last word transfers, ocnt returns to 0, m_valid drops next cycle, and the state returns to LOAD.
  - m_data and m_last stay stable while m_valid&&!m_ready.
- Stability: model_x must not change from FIRE until capture. This is guaranteed because s_ready=0 in FIRE, WAIT and DRAIN.
- Throughput: no input/output overlap; a new frame is accepted only after the full drain.
- Latency, LAT=1, m_ready=1 and no stalls:
  - Last input accept at edge E0.
  - model_en high E0→E1.
  - y captured at E2.
  - First m_valid visible after E2.
  - m_last transfer at E2+YD.
  - s_ready high again after edge E2+YD.
- Data handling: no arithmetic, pure bit movement; the YB-bit words are passed through unmodified.

Test Plan:
- Reset, then XD words s_data=n (n=0..63) with s_last on word 63 and a stub model where y[k]=x[k]+1 → model_en exactly one cycle high; model_x word 5=5; m_data sequence 1..16 with m_last only on the 16th word; frame_err never pulses.
- Same frame with s_valid toggling every other cycle and m_ready low for 3 cycles at word 7 → identical output data; m_data holds word 7 throughout the stall; no duplicate or dropped words.
- s_last asserted on word 10 → frame_err single pulse, no model_en; next full 64-word frame processes normally with correct output.
- 64 words with no s_last → frame_err pulse on acceptance of word 63, model_en still fires, and the output is correct.
- LAT=3 stub that changes y at every edge except exactly 3 edges after en → captured values are the 3-edge values.
- rstn asserted mid-DRAIN at word 8 → m_valid=0 immediately (asynchronous); after release s_ready=1, state is LOAD, and the next frame's output starts at word 0.
